// File: rtl/packet_tx.sv
// packet_tx: serialises PID, token and data packets LSB-first with CRC5/CRC16,
// handing one bit per valid/ready transfer to the line layer.
module packet_tx (
  input  logic        clk,
  input  logic        rst,
  input  logic        tx_start,
  input  logic [3:0]  tx_pid,
  input  logic [10:0] tx_addr,
  input  logic        tx_zlp,
  input  logic [7:0]  tx_data,
  input  logic        tx_data_last,
  input  logic        tx_data_valid,
  output logic        tx_data_ready,
  output logic        tx_bit,
  output logic        tx_bit_valid,
  input  logic        tx_bit_ready,
  output logic        tx_busy,
  output logic        tx_done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PID   = 3'd1;
  localparam logic [2:0] S_TOKEN = 3'd2;
  localparam logic [2:0] S_FETCH = 3'd3;
  localparam logic [2:0] S_DATA  = 3'd4;
  localparam logic [2:0] S_CRC   = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  logic [2:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  pid_q, pid_d;
  logic [10:0] addr_q, addr_d;
  logic        zlp_q, zlp_d;
  logic [7:0]  byte_q, byte_d;
  logic        last_q, last_d;
  logic [4:0]  crc5_q, crc5_d;
  logic [15:0] crc16_q, crc16_d;
  logic        bit_q, bit_d;
  logic        valid_q, valid_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        xfer;

  function automatic logic [4:0] crc5_step(input logic [4:0] c, input logic b);
    logic x;
    x = c[4] ^ b;
    return {c[3:0], 1'b0} ^ {2'b00, x, 1'b0, x};
  endfunction

  function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic b);
    logic x;
    x = c[15] ^ b;
    return {c[14:0], 1'b0} ^ {x, 12'b0, x, 1'b0, x};
  endfunction

  assign xfer = valid_q & tx_bit_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pid_d   = pid_q;
    addr_d  = addr_q;
    zlp_d   = zlp_q;
    byte_d  = byte_q;
    last_d  = last_q;
    crc5_d  = crc5_q;
    crc16_d = crc16_q;
    case (state_q)
      S_IDLE: begin
        if (tx_start) begin
          pid_d   = tx_pid;
          addr_d  = tx_addr;
          zlp_d   = tx_zlp;
          crc5_d  = 5'h1F;
          crc16_d = 16'hFFFF;
          cnt_d   = 4'd0;
          state_d = S_PID;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PID: begin
        if (xfer) begin
          if (cnt_q == 4'd7) begin
            cnt_d = 4'd0;
            case (pid_q[1:0])
              2'b01:   state_d = S_TOKEN;
              2'b11:   state_d = zlp_q ? S_CRC : S_FETCH;
              default: state_d = S_DONE;
            endcase
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end else begin
          state_d = S_PID;
        end
      end
      S_TOKEN: begin
        if (xfer) begin
          crc5_d = crc5_step(crc5_q, addr_q[cnt_q]);
          if (cnt_q == 4'd10) begin
            cnt_d   = 4'd0;
            state_d = S_CRC;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end else begin
          state_d = S_TOKEN;
        end
      end
      S_FETCH: begin
        // An empty source simply holds us here; underrun is not an error.
        if (tx_data_valid) begin
          byte_d  = tx_data;
          last_d  = tx_data_last;
          cnt_d   = 4'd0;
          state_d = S_DATA;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DATA: begin
        if (xfer) begin
          crc16_d = crc16_step(crc16_q, byte_q[cnt_q[2:0]]);
          if (cnt_q == 4'd7) begin
            cnt_d   = 4'd0;
            state_d = last_q ? S_CRC : S_FETCH;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end else begin
          state_d = S_DATA;
        end
      end
      S_CRC: begin
        if (xfer) begin
          if (cnt_q == ((pid_q[1:0] == 2'b01) ? 4'd4 : 4'd15)) begin
            cnt_d   = 4'd0;
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end else begin
          state_d = S_CRC;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are derived from the next state so they can be registered without a cycle of lag.
  always_comb begin
    bit_d = 1'b0;
    case (state_d)
      S_PID:   bit_d = cnt_d[2] ? ~pid_d[cnt_d[1:0]] : pid_d[cnt_d[1:0]];
      S_TOKEN: bit_d = addr_d[cnt_d];
      S_DATA:  bit_d = byte_d[cnt_d[2:0]];
      S_CRC: begin
        if (pid_d[1:0] == 2'b01) begin
          bit_d = ~crc5_d[3'd4 - cnt_d[2:0]];
        end else begin
          bit_d = ~crc16_d[4'd15 - cnt_d];
        end
      end
      default: bit_d = 1'b0;
    endcase
    valid_d = (state_d == S_PID) || (state_d == S_TOKEN) ||
              (state_d == S_DATA) || (state_d == S_CRC);
    ready_d = (state_d == S_FETCH);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      pid_q   <= 4'd0;
      addr_q  <= 11'd0;
      zlp_q   <= 1'b0;
      byte_q  <= 8'd0;
      last_q  <= 1'b0;
      crc5_q  <= 5'h1F;
      crc16_q <= 16'hFFFF;
      bit_q   <= 1'b0;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pid_q   <= pid_d;
      addr_q  <= addr_d;
      zlp_q   <= zlp_d;
      byte_q  <= byte_d;
      last_q  <= last_d;
      crc5_q  <= crc5_d;
      crc16_q <= crc16_d;
      bit_q   <= bit_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tx_bit        = bit_q;
  assign tx_bit_valid  = valid_q;
  assign tx_data_ready = ready_q;
  assign tx_busy       = busy_q;
  assign tx_done       = done_q;

endmodule

// File: tb/tb_packet_tx.sv
// Self-checking bench for packet_tx: directed vector table, hand-written corner
// sequences and randomised packets compared against a packet-level model.
module tb_packet_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        tx_start;
  logic [3:0]  tx_pid;
  logic [10:0] tx_addr;
  logic        tx_zlp;
  logic [7:0]  tx_data;
  logic        tx_data_last;
  logic        tx_data_valid;
  logic        tx_data_ready;
  logic        tx_bit;
  logic        tx_bit_valid;
  logic        tx_bit_ready;
  logic        tx_busy;
  logic        tx_done;

  int checks = 0;
  int errors = 0;

  typedef bit bitq_t[$];
  typedef logic [7:0] byteq_t[$];

  typedef struct {
    string       name;
    logic [3:0]  pid;
    logic [10:0] addr;
    logic        zlp;
    int          nbytes;
    logic [31:0] pl32;
    int          exp_len;
    int          head_len;
    logic [23:0] head;
  } vec_t;

  packet_tx dut (
    .clk(clk), .rst(rst), .tx_start(tx_start), .tx_pid(tx_pid), .tx_addr(tx_addr),
    .tx_zlp(tx_zlp), .tx_data(tx_data), .tx_data_last(tx_data_last),
    .tx_data_valid(tx_data_valid), .tx_data_ready(tx_data_ready), .tx_bit(tx_bit),
    .tx_bit_valid(tx_bit_valid), .tx_bit_ready(tx_bit_ready), .tx_busy(tx_busy),
    .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Generic serial CRC: shift left, feed back the polynomial on (msb ^ data bit).
  function automatic int unsigned crc_calc(input bitq_t msg, input int w,
                                           input int unsigned poly, input int unsigned init);
    int unsigned c = init;
    int unsigned mask = (32'd1 << w) - 32'd1;
    foreach (msg[i]) begin
      bit fb = (((c >> (w - 1)) & 32'd1) != 32'd0) ^ msg[i];
      c = (c << 1) & mask;
      if (fb) c = c ^ poly;
    end
    return c;
  endfunction

  function automatic void build(input logic [3:0] pid, input logic [10:0] addr, input logic zlp,
                                input byteq_t pl, output bitq_t q);
    bitq_t body;
    int unsigned c;
    q = {};
    body = {};
    for (int i = 0; i < 4; i++) q.push_back(pid[i]);
    for (int i = 0; i < 4; i++) q.push_back(!pid[i]);
    if (pid[1:0] == 2'b01) begin
      for (int i = 0; i < 11; i++) body.push_back(addr[i]);
      c = crc_calc(body, 5, 32'h05, 32'h1F);
      foreach (body[i]) q.push_back(body[i]);
      for (int i = 4; i >= 0; i--) q.push_back(!c[i]);
    end else if (pid[1:0] == 2'b11) begin
      if (!zlp) foreach (pl[j]) for (int k = 0; k < 8; k++) body.push_back(pl[j][k]);
      c = crc_calc(body, 16, 32'h8005, 32'hFFFF);
      foreach (body[i]) q.push_back(body[i]);
      for (int i = 15; i >= 0; i--) q.push_back(!c[i]);
    end
  endfunction

  function automatic logic [7:0] get_byte(input bitq_t q, input int b);
    logic [7:0] v = 8'h00;
    for (int k = 0; k < 8; k++) if (8 * b + k < q.size()) v[k] = q[8 * b + k];
    return v;
  endfunction

  // Drives one packet; called and returned at a negedge with the DUT idle.
  task automatic run_packet(input string tag, input logic [3:0] pid, input logic [10:0] addr,
                            input logic zlp, input byteq_t pl, input bit rnd_ready,
                            input int delay, input bit poke_start, output bitq_t got);
    bitq_t exp, tail;
    int cyc = 0, bi = 0, wait_cnt = 0, valid_cycles = 0, stall_bad = 0, under_bad = 0;
    int mis = -1;
    bit done_seen = 1'b0, prev_stall = 1'b0, prev_bit = 1'b0;
    got = {};
    build(pid, addr, zlp, pl, exp);
    tx_start = 1'b1; tx_pid = pid; tx_addr = addr; tx_zlp = zlp;
    @(negedge clk);
    tx_start = 1'b0;
    check({tag, " start_busy"}, {31'd0, tx_busy}, 32'd1);
    check({tag, " start_valid"}, {31'd0, tx_bit_valid}, 32'd1);
    while (cyc < 2000) begin
      if (prev_stall && (tx_bit !== prev_bit)) stall_bad++;
      if (tx_data_ready && tx_bit_valid) under_bad++;
      if (tx_done) begin
        done_seen = 1'b1;
        break;
      end
      if (tx_bit_valid) valid_cycles++;
      tx_bit_ready = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      tx_start = poke_start && (cyc == 5 || cyc == 20);
      tx_pid = poke_start ? 4'b0010 : pid;
      tx_addr = 11'($urandom);
      if (tx_data_ready && bi < pl.size()) begin
        if (wait_cnt >= delay) begin
          tx_data_valid = 1'b1;
          tx_data = pl[bi];
          tx_data_last = (bi == pl.size() - 1);
          bi++;
          wait_cnt = 0;
        end else begin
          tx_data_valid = 1'b0;
          tx_data = 8'($urandom);
          wait_cnt++;
        end
      end else begin
        tx_data_valid = 1'b0;
        tx_data = 8'($urandom);
        tx_data_last = 1'($urandom);
      end
      if (tx_bit_valid && tx_bit_ready) got.push_back(tx_bit);
      prev_stall = tx_bit_valid && !tx_bit_ready;
      prev_bit = tx_bit;
      @(negedge clk);
      cyc++;
    end
    tx_start = 1'b0;
    tx_data_valid = 1'b0;
    check({tag, " done_seen"}, {31'd0, done_seen}, 32'd1);
    if (done_seen) begin
      check({tag, " valid_at_done"}, {31'd0, tx_bit_valid}, 32'd0);
      check({tag, " busy_at_done"}, {31'd0, tx_busy}, 32'd1);
      @(negedge clk);
      check({tag, " done_width"}, {31'd0, tx_done}, 32'd0);
      check({tag, " idle_busy"}, {31'd0, tx_busy}, 32'd0);
    end else begin
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
    end
    check({tag, " length"}, got.size(), exp.size());
    foreach (exp[i]) if (mis < 0 && (i >= got.size() || got[i] != exp[i])) mis = i;
    check({tag, " seq_first_diff"}, mis, -1);
    check({tag, " stall_stable"}, stall_bad, 0);
    check({tag, " valid_in_fetch"}, under_bad, 0);
    if (!rnd_ready) check({tag, " valid_cycles"}, valid_cycles, exp.size());
    tail = {};
    for (int i = 8; i < got.size(); i++) tail.push_back(got[i]);
    if (pid[1:0] == 2'b01) check({tag, " crc5_residual"}, crc_calc(tail, 5, 32'h05, 32'h1F), 32'h0C);
    if (pid[1:0] == 2'b11) check({tag, " crc16_residual"}, crc_calc(tail, 16, 32'h8005, 32'hFFFF), 32'h800D);
  endtask

  function automatic vec_t mk(input string n, input logic [3:0] p, input logic [10:0] a,
                              input logic z, input int nb, input logic [31:0] pl32,
                              input int len, input int hl, input logic [23:0] h);
    vec_t v;
    v.name = n; v.pid = p; v.addr = a; v.zlp = z; v.nbytes = nb; v.pl32 = pl32;
    v.exp_len = len; v.head_len = hl; v.head = h;
    return v;
  endfunction

  initial begin
    vec_t vecs[$];
    bitq_t got, ref_data1;
    byteq_t pl;
    int xfers;
    bit saw_done;

    rst = 1'b1; tx_start = 1'b0; tx_pid = 4'd0; tx_addr = 11'd0; tx_zlp = 1'b0;
    tx_data = 8'd0; tx_data_last = 1'b0; tx_data_valid = 1'b0; tx_bit_ready = 1'b1;

    vecs.push_back(mk("ACK",     4'b0010, 11'd0,    1'b0, 0, 32'h0,         8,  8, 24'h0000D2));
    vecs.push_back(mk("SETUP",   4'b1101, 11'd0,    1'b0, 0, 32'h0,         24, 24, 24'h10002D));
    vecs.push_back(mk("DATA0Z",  4'b0011, 11'd0,    1'b1, 0, 32'h0,         24, 24, 24'h0000C3));
    vecs.push_back(mk("DATA1",   4'b1011, 11'd0,    1'b0, 4, 32'h04030201,  56, 8,  24'h00004B));
    vecs.push_back(mk("NAK",     4'b1010, 11'd0,    1'b0, 0, 32'h0,         8,  8,  24'h00005A));
    vecs.push_back(mk("IN",      4'b1001, 11'h5A3,  1'b0, 0, 32'h0,         24, 8,  24'h000069));
    vecs.push_back(mk("PRE",     4'b1100, 11'd0,    1'b0, 0, 32'h0,         8,  8,  24'h00003C));
    vecs.push_back(mk("DATA0B1", 4'b0011, 11'd0,    1'b0, 1, 32'h000000A5,  32, 8,  24'h0000C3));

    repeat (2) @(negedge clk);
    tx_start = 1'b1;
    @(negedge clk);
    check("reset bit", {31'd0, tx_bit}, 32'd0);
    check("reset valid", {31'd0, tx_bit_valid}, 32'd0);
    check("reset data_ready", {31'd0, tx_data_ready}, 32'd0);
    check("reset busy", {31'd0, tx_busy}, 32'd0);
    check("reset done", {31'd0, tx_done}, 32'd0);
    tx_start = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("start_in_reset_ignored", {31'd0, tx_busy}, 32'd0);

    foreach (vecs[v]) begin
      pl = {};
      for (int b = 0; b < vecs[v].nbytes; b++) pl.push_back(vecs[v].pl32[8 * b +: 8]);
      run_packet(vecs[v].name, vecs[v].pid, vecs[v].addr, vecs[v].zlp, pl, 1'b0, 0, 1'b0, got);
      check({vecs[v].name, " table_len"}, got.size(), vecs[v].exp_len);
      for (int b = 0; b < vecs[v].head_len / 8; b++)
        check({vecs[v].name, " wire_byte"}, get_byte(got, b), vecs[v].head[8 * b +: 8]);
      for (int b = 0; b < vecs[v].nbytes; b++)
        check({vecs[v].name, " payload_byte"}, get_byte(got, b + 1), vecs[v].pl32[8 * b +: 8]);
      if (vecs[v].name == "DATA1") ref_data1 = got;
    end

    // DATA1 again with line stalls and a 10-cycle source underrun before every byte.
    pl = {8'h01, 8'h02, 8'h03, 8'h04};
    run_packet("DATA1_gaps", 4'b1011, 11'd0, 1'b0, pl, 1'b1, 10, 1'b0, got);
    check("DATA1_gaps same_as_nogap", {31'd0, got == ref_data1}, 32'd1);

    // tx_start pulses while busy must not disturb the packet.
    run_packet("DATA1_restart", 4'b1011, 11'd0, 1'b0, pl, 1'b0, 2, 1'b1, got);

    // Reset after 12 bits of a token, with tx_start held during reset.
    tx_start = 1'b1; tx_pid = 4'b0001; tx_addr = 11'h3C5; tx_zlp = 1'b0;
    @(negedge clk);
    tx_start = 1'b0;
    xfers = 0;
    for (int c = 0; c < 100 && xfers < 12; c++) begin
      tx_bit_ready = 1'b1;
      if (tx_bit_valid) xfers++;
      @(negedge clk);
    end
    check("rst_mid xfers_before", xfers, 12);
    rst = 1'b1; tx_start = 1'b1; tx_pid = 4'b0010;
    @(negedge clk);
    check("rst_mid valid", {31'd0, tx_bit_valid}, 32'd0);
    check("rst_mid busy", {31'd0, tx_busy}, 32'd0);
    check("rst_mid done", {31'd0, tx_done}, 32'd0);
    check("rst_mid bit", {31'd0, tx_bit}, 32'd0);
    check("rst_mid data_ready", {31'd0, tx_data_ready}, 32'd0);
    rst = 1'b0; tx_start = 1'b0;
    saw_done = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (tx_done || tx_busy) saw_done = 1'b1;
    end
    check("rst_mid stays_idle", {31'd0, saw_done}, 32'd0);
    pl = {};
    run_packet("ACK_after_rst", 4'b0010, 11'd0, 1'b0, pl, 1'b0, 0, 1'b0, got);
    check("ACK_after_rst byte", get_byte(got, 0), 8'hD2);

    // Randomised packets of every class against the model.
    for (int n = 0; n < 25; n++) begin
      int cls = $urandom_range(0, 3);
      logic [3:0] pid = 4'($urandom);
      logic z = 1'b0;
      pl = {};
      case (cls)
        0: pid[1:0] = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b00;
        1: pid[1:0] = 2'b01;
        2: begin pid[1:0] = 2'b11; z = 1'b1; end
        default: begin
          pid[1:0] = 2'b11;
          repeat ($urandom_range(1, 5)) pl.push_back(8'($urandom));
        end
      endcase
      run_packet($sformatf("rnd%0d", n), pid, 11'($urandom), z, pl, 1'b1,
                 $urandom_range(0, 3), 1'b0, got);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/packet_tx.md
PACKET_TX -- requirements
Module: packet_tx

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
REQ-003 The block SHALL have these request ports:
- tx_start  input  1  one-cycle request to send a packet.
- tx_pid  input  4  PID, sampled with tx_start.
- tx_addr  input  11  token field {endp[3:0], addr[6:0]}, sampled with tx_start.
- tx_zlp  input  1  data PID with zero payload, sampled with tx_start.
REQ-004 The block SHALL have these payload ports:
- tx_data  input  8  payload byte.
- tx_data_last  input  1  marks the final payload byte.
- tx_data_valid  input  1  payload byte present.
- tx_data_ready  output  1  block accepts a byte this cycle.
REQ-005 The block SHALL have these line-layer and status ports:
- tx_bit  output  1  current serial bit, LSB-first.
- tx_bit_valid  output  1  tx_bit is presented.
- tx_bit_ready  input  1  line layer takes tx_bit this cycle.
- tx_busy  output  1  packet in progress.
- tx_done  output  1  one-cycle pulse after the last bit is taken; the line layer then emits EOP.

Function
REQ-006 A transfer SHALL occur on a cycle with tx_bit_valid=1 and tx_bit_ready=1; the next bit SHALL appear the following cycle, so back-to-back transfers run at one bit per cycle.
REQ-007 tx_bit and tx_bit_valid SHALL be registered, and tx_bit SHALL stay stable while tx_bit_valid=1 and tx_bit_ready=0.
REQ-008 The states SHALL be IDLE, PID, TOKEN, FETCH, DATA, CRC and DONE.
REQ-009 IDLE: tx_start SHALL latch the inputs and enter PID; tx_bit_valid=1 and tx_busy=1 from the next cycle.
REQ-010 tx_start SHALL be ignored outside IDLE.
REQ-011 PID: the block SHALL send 8 bits tx_pid[0..3] then ~tx_pid[0..3]; after the 8th transfer the next state SHALL be selected by tx_pid[1:0]:
- 01 -> TOKEN.
- 11 -> FETCH, or CRC when tx_zlp=1.
- 10 or 00 -> DONE.
REQ-012 TOKEN: the block SHALL send tx_addr[0..10], updating CRC5 per bit, then enter CRC.
- Update: x=crc5[4]^bit; crc5={crc5[3:0],0}^{0,0,x,0,x}.
- Initial value: 5'h1F at tx_start.
REQ-013 FETCH: tx_data_ready=1 and tx_bit_valid=0.
- tx_data_valid=1 SHALL latch the byte and last flag and enter DATA next cycle.
- With no valid byte, the block SHALL wait indefinitely (underrun stall, no error).
REQ-014 DATA: the block SHALL send the byte bits [0..7], updating CRC16 per bit.
- Update: x=crc16[15]^bit; crc16={crc16[14:0],0}^{x,12'b0,x,0,x}.
- Initial value: 16'hFFFF at tx_start.
- After bit 7: return to FETCH, or enter CRC if the last flag is set.
REQ-015 CRC: the block SHALL send the inverted CRC MSB-first (~crc5[4..0] for tokens, ~crc16[15..0] for data), with the register frozen during CRC.
REQ-016 DONE: tx_bit_valid=0, then a one-cycle tx_done=1, then IDLE with tx_busy=0.
REQ-017 tx_start SHALL be accepted from the cycle after tx_done.
REQ-018 Packet lengths SHALL be:
- Handshake/special: 8 bits.
- Token: 24 bits.
- Data: 24+8N bits for N payload bytes (N=0 with tx_zlp).
REQ-019 tx_data_ready SHALL be 1 only in FETCH.
REQ-020 A bit counter SHALL wrap per phase: 0-7 for PID/DATA, 0-10 for TOKEN, 0-4 or 0-15 for CRC.
REQ-021 Idle cycles with tx_bit_ready=0 SHALL NOT alter the CRC or counters.

Reset
REQ-022 rst=1 SHALL force the following state on the next clock edge, including mid-packet, with no tx_done issued:
- IDLE.
- tx_bit=0, tx_bit_valid=0, tx_data_ready=0, tx_busy=0, tx_done=0.
- crc5=5'h1F, crc16=16'hFFFF, counters 0.
REQ-023 tx_start asserted during rst SHALL be ignored.

Verification
REQ-024 ACK (pid 0010), tx_bit_ready tied high -> wire byte 0xD2 (bits 0,1,0,0,1,0,1,1); 8 valid cycles, then tx_done.
REQ-025 SETUP (pid 1101), tx_addr=0 -> wire bytes 0x2D,0x00,0x10; 24 bits total; matches the packet receiver's CRC5 check.
REQ-026 DATA0 (pid 0011), tx_zlp=1 -> wire bytes 0xC3,0x00,0x00; 24 bits total.
REQ-027 DATA1 (pid 1011), payload 0x01,0x02,0x03,0x04 with last on 0x04 -> 0x4B, payload, CRC16 bytes; 56 bits total; loopback into the packet receiver yields the packet-valid flag set.
REQ-028 Randomised tx_bit_ready gaps and tx_data_valid delayed 10 cycles -> identical bit sequence to REQ-027; tx_bit stable during stalls; tx_bit_valid=0 throughout the underrun.
REQ-029 rst pulsed after 12 bits of a token -> outputs idle next cycle with no tx_done; a new ACK then sends correctly.
